// File: rtl/bist_pkg.sv
// Shared constants for the BIST session controller: state encoding, default
// datapath sizing and the default golden signature.
package bist_pkg;

    localparam int SIG_W_DEF    = 4;
    localparam int N_CYCLES_DEF = 31;
    localparam int CNT_W_DEF    = 5;

    localparam logic [SIG_W_DEF-1:0] GOLDEN_DEF = 4'b0000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        CLEAR   = ST_CLEAR,
        RUN     = ST_RUN,
        CAPTURE = ST_CAPTURE,
        DONE    = ST_DONE
    } bist_state_e;

endpackage

// File: rtl/bist_cycle_cnt.sv
// Run-length counter for a BIST session: clear, enable, and a terminal-count
// flag raised while the count equals N_CYCLES-1.
module bist_cycle_cnt #(
    parameter int CNT_W    = 5,
    parameter int N_CYCLES = 31
) (
    input  logic clk,
    input  logic rst_b,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CNT_W'(N_CYCLES - 1));

endmodule

// File: rtl/bist_ctrl.sv
// BIST session controller: clears and runs the LFSR/CUT/SISR datapath for
// N_CYCLES clocks, captures the signature and compares it with GOLDEN.
// Optional sticky failure flag: define BIST_CTRL_STICKY_FAIL_EN.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int               SIG_W    = SIG_W_DEF,
    parameter int               N_CYCLES = N_CYCLES_DEF,
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [SIG_W-1:0] GOLDEN   = GOLDEN_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [SIG_W-1:0] sig,
    output logic             bist_rst_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig_cap,
`ifdef BIST_CTRL_STICKY_FAIL_EN
    output logic             fail_sticky,
`endif
    output logic [2:0]       dbg_state
);

    bist_state_e      r_state;
    bist_state_e      w_next;
    logic             r_bist_rst_b, w_bist_rst_b;
    logic             r_busy,       w_busy;
    logic             r_done,       w_done;
    logic             r_pass,       w_pass;
    logic [SIG_W-1:0] r_sig_cap,    w_sig_cap;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_tc;
    logic             w_capture;

    bist_cycle_cnt #(
        .CNT_W    (CNT_W),
        .N_CYCLES (N_CYCLES)
    ) u_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= IDLE;
            r_bist_rst_b <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_sig_cap    <= '0;
        end else begin
            r_state      <= w_next;
            r_bist_rst_b <= w_bist_rst_b;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_pass       <= w_pass;
            r_sig_cap    <= w_sig_cap;
        end
    end

    // Outputs are computed alongside the next state so every port is a flop.
    always_comb begin
        w_next       = r_state;
        w_bist_rst_b = r_bist_rst_b;
        w_busy       = r_busy;
        w_done       = r_done;
        w_pass       = r_pass;
        w_sig_cap    = r_sig_cap;
        w_cnt_clr    = 1'b1;
        w_cnt_en     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next       = CLEAR;
                    w_busy       = 1'b1;
                    w_done       = 1'b0;
                    w_pass       = 1'b0;
                    w_bist_rst_b = 1'b0;
                end
            end
            CLEAR: begin
                w_next       = RUN;
                w_bist_rst_b = 1'b1;
            end
            RUN: begin
                w_cnt_clr = 1'b0;
                w_cnt_en  = !w_tc;
                if (w_tc) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                w_next       = DONE;
                w_capture    = 1'b1;
                w_sig_cap    = sig;
                w_pass       = (sig == GOLDEN);
                w_done       = 1'b1;
                w_busy       = 1'b0;
                w_bist_rst_b = 1'b0;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef BIST_CTRL_STICKY_FAIL_EN
    logic r_fail_sticky;

    // Only rst_b clears this; later passing sessions leave it set.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_fail_sticky <= 1'b0;
        end else if (w_capture && (sig != GOLDEN)) begin
            r_fail_sticky <= 1'b1;
        end
    end

    assign fail_sticky = r_fail_sticky;
`endif

    assign bist_rst_b = r_bist_rst_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign sig_cap    = r_sig_cap;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl with GOLDEN=4'hA and N_CYCLES=31;
// define BIST_CTRL_STICKY_FAIL_EN to cover the sticky failure flag.
module tb_bist_ctrl;

    localparam int         N = 31;
    localparam logic [3:0] G = 4'hA;

    logic       clk   = 1'b0;
    logic       rst_b = 1'b1;
    logic       start = 1'b0;
    logic [3:0] sig   = 4'h0;
    logic       bist_rst_b, busy, done, pass;
    logic [3:0] sig_cap;
    logic [2:0] dbg_state;
`ifdef BIST_CTRL_STICKY_FAIL_EN
    logic       fail_sticky;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    bist_ctrl #(
        .SIG_W    (4),
        .N_CYCLES (N),
        .CNT_W    (5),
        .GOLDEN   (G)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .sig         (sig),
        .bist_rst_b  (bist_rst_b),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .sig_cap     (sig_cap),
`ifdef BIST_CTRL_STICKY_FAIL_EN
        .fail_sticky (fail_sticky),
`endif
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: a session is a count of edges since start was accepted.
    bit         m_act    = 1'b0;
    int         m_phase  = 0;
    logic       m_done   = 1'b0;
    logic       m_pass   = 1'b0;
    logic       m_sticky = 1'b0;
    logic [3:0] m_cap    = 4'h0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_act = 1'b0; m_phase = 0; m_done = 1'b0;
            m_pass = 1'b0; m_sticky = 1'b0; m_cap = 4'h0;
        end else if (m_act) begin
            m_phase++;
            if (m_phase == N + 2) begin
                m_cap  = sig;
                m_pass = (sig == G);
                m_sticky = m_sticky | (sig != G);
                m_done = 1'b1;
                m_act  = 1'b0;
            end
        end else if (start) begin
            m_act = 1'b1; m_phase = 0; m_done = 1'b0; m_pass = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",       32'(busy),       32'(m_act));
            chk("bist_rst_b", 32'(bist_rst_b), 32'(m_act && m_phase >= 1));
            chk("done",       32'(done),       32'(m_done));
            chk("pass",       32'(pass),       32'(m_pass));
            chk("sig_cap",    32'(sig_cap),    32'(m_cap));
`ifdef BIST_CTRL_STICKY_FAIL_EN
            chk("fail_sticky", 32'(fail_sticky), 32'(m_sticky));
`endif
        end
    end

    // Caller sits 2 ns after a rising edge; returns 2 ns after E33.
    task automatic run_session(input logic [3:0] s, input string nm);
        sig   = s;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (32) @(posedge clk);
        #2;
        chk({nm, "_e32_done"}, 32'(done), 32'd0);
        chk({nm, "_e32_brst"}, 32'(bist_rst_b), 32'd1);
        @(posedge clk); #2;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_brst"}, 32'(bist_rst_b), 32'd0);
        chk({nm, "_pass"}, 32'(pass), 32'(s == 4'hA));
        chk({nm, "_cap"},  32'(sig_cap), 32'(s));
    endtask

    initial begin
        #1;
        rst_b = 1'b0;
        start = 1'b1;
        cmp_en = 1'b1;
        #25;
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_brst",  32'(bist_rst_b), 32'd0);
        @(posedge clk); #2;
        start = 1'b0;
        rst_b = 1'b1;
        @(posedge clk); #2;

        run_session(4'hA, "pass");
        @(posedge clk); #2;
        run_session(4'h5, "fail");
`ifdef BIST_CTRL_STICKY_FAIL_EN
        chk("fail_sticky_set", 32'(fail_sticky), 32'd1);
`endif
        @(posedge clk); #2;

        // start held through the run and past DONE: back-to-back sessions
        sig   = 4'hA;
        start = 1'b1;
        @(posedge clk); #2;
        repeat (32) @(posedge clk);
        #2;
        chk("held_e32_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        chk("held_e33_done", 32'(done), 32'd1);
        @(posedge clk); #2;
        chk("held_e34_done", 32'(done), 32'd0);
        chk("held_e34_pass", 32'(pass), 32'd0);
        chk("held_e34_busy", 32'(busy), 32'd1);
        repeat (32) @(posedge clk);
        #2;
        chk("held_e66_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        chk("held_e67_done", 32'(done), 32'd1);
        chk("held_e67_pass", 32'(pass), 32'd1);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // reset pulse in the middle of RUN
        sig   = 4'hA;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("mid_brst_hi", 32'(bist_rst_b), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("mid_brst_lo", 32'(bist_rst_b), 32'd0);
        chk("mid_busy",    32'(busy), 32'd0);
        chk("mid_state",   32'(dbg_state), 32'd0);
        @(posedge clk); #2;
        rst_b = 1'b1;
        @(posedge clk); #2;
        run_session(4'hA, "fresh");
`ifdef BIST_CTRL_STICKY_FAIL_EN
        chk("fresh_sticky", 32'(fail_sticky), 32'd0);
`endif
        @(posedge clk); #2;

        // signature moves every cycle; only the value before E33 counts
        sig   = 4'h0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #2;
            sig = 4'(i + 5);
        end
        @(posedge clk); #2;
        chk("vary_cap",  32'(sig_cap), 32'h5);
        chk("vary_pass", 32'(pass), 32'd0);
        chk("vary_done", 32'(done), 32'd1);
        @(posedge clk); #2;

        // failing then passing session
        rst_b = 1'b0;
        @(posedge clk); #2;
        rst_b = 1'b1;
        @(posedge clk); #2;
        run_session(4'h3, "stk_fail");
        @(posedge clk); #2;
        run_session(4'hA, "stk_pass");
`ifdef BIST_CTRL_STICKY_FAIL_EN
        chk("stk_keep", 32'(fail_sticky), 32'd1);
`endif
        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
